// File: rtl/regfile_port_ctrl_pkg.sv
// Shared constants and types for the register-file port controller.
package regfile_port_ctrl_pkg;

   localparam int unsigned RF_DATA_W = 16;
   localparam int unsigned RF_ADDR_W = 3;

   // R0 reads as zero and is never written.
   localparam logic [RF_ADDR_W-1:0] R0_IDX = '0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] rd;
      logic [RF_DATA_W-1:0] data;
   } wbq_entry_t;

endpackage

// File: rtl/regfile_wbq.sv
// Writeback queue: FIFO with occupancy count and an age-ordered view of
// every entry (index 0 = head/oldest) for the forwarding compare.
module regfile_wbq
   import regfile_port_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wbq_entry_t                 push_entry,
   input  logic                       pop,
   output logic [$clog2(DEPTH):0]     count,
   output wbq_entry_t                 ent [DEPTH],
   output logic [DEPTH-1:0]           ent_valid
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wbq_entry_t        mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   // Storage write; contents need no reset since validity comes from count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Rotate storage so that index 0 is the head and higher indices are younger.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent[i]       = mem[rd_ptr + PTR_W'(i)];
         ent_valid[i] = (CNT_W'(i) < count);
      end
   end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: buffers writebacks, drains them into the
// write port, and serves operand reads with forwarding from pending writes.
module regfile_port_ctrl
   import regfile_port_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W    = RF_DATA_W,
   parameter int unsigned ADDR_W    = RF_ADDR_W,
   parameter int unsigned WBQ_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wb_valid,
   output logic                         wb_ready,
   input  logic [ADDR_W-1:0]            wb_rd,
   input  logic [DATA_W-1:0]            wb_data,
   input  logic                         drain_en,
   input  logic                         rd_req_valid,
   output logic                         rd_req_ready,
   input  logic [ADDR_W-1:0]            rs1,
   input  logic [ADDR_W-1:0]            rs2,
   output logic                         op_valid,
   input  logic                         op_ready,
   output logic [DATA_W-1:0]            op1,
   output logic [DATA_W-1:0]            op2,
   output logic                         rf_write_en,
   output logic [ADDR_W-1:0]            rf_a3,
   output logic [DATA_W-1:0]            rf_wd3,
   output logic [ADDR_W-1:0]            rf_a1,
   output logic [ADDR_W-1:0]            rf_a2,
   input  logic [DATA_W-1:0]            rf_rd1,
   input  logic [DATA_W-1:0]            rf_rd2,
   output logic [$clog2(WBQ_DEPTH):0]   wbq_count
);

   localparam int unsigned CNT_W = $clog2(WBQ_DEPTH) + 1;

   wbq_entry_t              q_ent [WBQ_DEPTH];
   logic [WBQ_DEPTH-1:0]    q_valid;
   logic                    q_nonempty;
   logic                    wb_fire;
   logic                    q_push;
   logic                    q_pop;
   logic                    rd_fire;
   logic [DATA_W-1:0]       fwd1;
   logic [DATA_W-1:0]       fwd2;

   regfile_wbq #(
      .DEPTH (WBQ_DEPTH)
   ) u_wbq (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .push_entry ('{rd: wb_rd, data: wb_data}),
      .pop        (q_pop),
      .count      (wbq_count),
      .ent        (q_ent),
      .ent_valid  (q_valid)
   );

   // Handshake decode; write port is held off while reset is asserted so a
   // reset landing mid-drain discards the queue without committing its head.
   always_comb begin
      q_nonempty   = (wbq_count != '0);
      wb_ready     = (wbq_count != CNT_W'(WBQ_DEPTH));
      wb_fire      = wb_valid && wb_ready;
      q_push       = wb_fire && (wb_rd != R0_IDX);
      rf_write_en  = rst && drain_en && q_nonempty;
      q_pop        = rf_write_en;
      rf_a3        = q_nonempty ? q_ent[0].rd   : '0;
      rf_wd3       = q_nonempty ? q_ent[0].data : '0;
      rf_a1        = rs1;
      rf_a2        = rs2;
      rd_req_ready = !op_valid || op_ready;
      rd_fire      = rd_req_valid && rd_req_ready;
   end

   // Forwarding mux: later assignments override earlier ones, so the scan runs
   // oldest to youngest and the same-cycle writeback and R0 rules come last.
   always_comb begin
      fwd1 = rf_rd1;
      fwd2 = rf_rd2;
      for (int unsigned i = 0; i < WBQ_DEPTH; i++) begin
         if (q_valid[i] && (q_ent[i].rd == rs1)) begin
            fwd1 = q_ent[i].data;
         end
         if (q_valid[i] && (q_ent[i].rd == rs2)) begin
            fwd2 = q_ent[i].data;
         end
      end
      if (wb_fire && (wb_rd == rs1)) begin
         fwd1 = wb_data;
      end
      if (wb_fire && (wb_rd == rs2)) begin
         fwd2 = wb_data;
      end
      if (rs1 == R0_IDX) begin
         fwd1 = '0;
      end
      if (rs2 == R0_IDX) begin
         fwd2 = '0;
      end
   end

   // Single operand output register: load on accept, clear when consumed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_valid <= 1'b0;
         op1      <= '0;
         op2      <= '0;
      end else if (rd_fire) begin
         op_valid <= 1'b1;
         op1      <= fwd1;
         op2      <= fwd2;
      end else if (op_ready) begin
         op_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed cycle-by-cycle bench for regfile_port_ctrl with a behavioural
// 8x16 register file attached to the write and read ports.
module tb_regfile_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_rd;
   logic [15:0] wb_data;
   logic        drain_en;
   logic        rd_req_valid;
   logic        rd_req_ready;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic        op_valid;
   logic        op_ready;
   logic [15:0] op1;
   logic [15:0] op2;
   logic        rf_write_en;
   logic [2:0]  rf_a3;
   logic [15:0] rf_wd3;
   logic [2:0]  rf_a1;
   logic [2:0]  rf_a2;
   logic [15:0] rf_rd1;
   logic [15:0] rf_rd2;
   logic [2:0]  wbq_count;

   int checks = 0;
   int errors = 0;
   int n_writes = 0;
   int n_r0_writes = 0;

   logic [15:0] rfm [8] = '{16'h0000, 16'hF001, 16'hF002, 16'hF003,
                            16'hF004, 16'hF005, 16'hF006, 16'hF007};

   regfile_port_ctrl #(
      .DATA_W    (16),
      .ADDR_W    (3),
      .WBQ_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .drain_en     (drain_en),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rs1          (rs1),
      .rs2          (rs2),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op1          (op1),
      .op2          (op2),
      .rf_write_en  (rf_write_en),
      .rf_a3        (rf_a3),
      .rf_wd3       (rf_wd3),
      .rf_a1        (rf_a1),
      .rf_a2        (rf_a2),
      .rf_rd1       (rf_rd1),
      .rf_rd2       (rf_rd2),
      .wbq_count    (wbq_count)
   );

   always #5 clk = ~clk;

   // Register file model: synchronous write, asynchronous reads.
   always @(posedge clk) begin
      if (rf_write_en) begin
         rfm[rf_a3] <= rf_wd3;
         n_writes   <= n_writes + 1;
         if (rf_a3 == 3'd0) n_r0_writes <= n_r0_writes + 1;
      end
   end
   assign rf_rd1 = rfm[rf_a1];
   assign rf_rd2 = rfm[rf_a2];

   typedef struct {
      logic        rst;
      logic        wv;
      logic [2:0]  wrd;
      logic [15:0] wd;
      logic        dr;
      logic        rv;
      logic [2:0]  s1;
      logic [2:0]  s2;
      logic        ordy;
      logic        e_wbr;
      logic        e_rqr;
      logic        e_ov;
      logic        e_chkop;
      logic [15:0] e_op1;
      logic [15:0] e_op2;
      logic        e_we;
      logic [2:0]  e_a3;
      logic [15:0] e_wd3;
      logic [2:0]  e_cnt;
   } vec_t;

   localparam int NV = 23;
   vec_t tbl [NV];

   task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic wv, input logic [2:0] wrd, input logic [15:0] wd,
                        input logic dr, input logic rv, input logic [2:0] s1, input logic [2:0] s2,
                        input logic ordy);
      rst = r; wb_valid = wv; wb_rd = wrd; wb_data = wd; drain_en = dr;
      rd_req_valid = rv; rs1 = s1; rs2 = s2; op_ready = ordy;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //           rst wv wrd wd        dr rv s1 s2 ordy | wbr rqr ov chk op1       op2       we a3 wd3       cnt
      tbl[0]  = '{1'b0,1'b1,3'd3,16'hAAAA,1'b0,1'b1,3'd1,3'd2,1'b1, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[1]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[2]  = '{1'b1,1'b1,3'd5,16'h1234,1'b1,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[3]  = '{1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b1,3'd5,16'h1234,3'd1};
      tbl[4]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[5]  = '{1'b1,1'b1,3'd1,16'h0011,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[6]  = '{1'b1,1'b1,3'd2,16'h0022,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd1,16'h0011,3'd1};
      tbl[7]  = '{1'b1,1'b1,3'd1,16'h0111,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd1,16'h0011,3'd2};
      tbl[8]  = '{1'b1,1'b1,3'd4,16'h0044,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd1,16'h0011,3'd3};
      tbl[9]  = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,3'd1,3'd2,1'b0, 1'b0,1'b1,1'b0,1'b1,16'h0000,16'h0000,1'b0,3'd1,16'h0011,3'd4};
      tbl[10] = '{1'b1,1'b1,3'd7,16'h0777,1'b1,1'b0,3'd0,3'd0,1'b0, 1'b0,1'b0,1'b1,1'b1,16'h0111,16'h0022,1'b1,3'd1,16'h0011,3'd4};
      tbl[11] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,1'b1,3'd4,3'd1,1'b0, 1'b1,1'b0,1'b1,1'b1,16'h0111,16'h0022,1'b1,3'd2,16'h0022,3'd3};
      tbl[12] = '{1'b1,1'b1,3'd3,16'h0333,1'b1,1'b0,3'd0,3'd0,1'b1, 1'b1,1'b1,1'b1,1'b1,16'h0111,16'h0022,1'b1,3'd1,16'h0111,3'd2};
      tbl[13] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,3'd4,16'h0044,3'd2};
      tbl[14] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b1,3'd3,16'h0333,3'd1};
      tbl[15] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[16] = '{1'b1,1'b1,3'd6,16'hBEEF,1'b0,1'b1,3'd6,3'd0,1'b1, 1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};
      tbl[17] = '{1'b1,1'b1,3'd0,16'hFFFF,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b0,1'b1,1'b1,16'hBEEF,16'h0000,1'b0,3'd6,16'hBEEF,3'd1};
      tbl[18] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,3'd3,3'd5,1'b0, 1'b1,1'b0,1'b1,1'b1,16'hBEEF,16'h0000,1'b0,3'd6,16'hBEEF,3'd1};
      tbl[19] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b1,3'd3,3'd5,1'b1, 1'b1,1'b1,1'b1,1'b1,16'hBEEF,16'h0000,1'b0,3'd6,16'hBEEF,3'd1};
      tbl[20] = '{1'b1,1'b0,3'd0,16'h0000,1'b1,1'b1,3'd1,3'd6,1'b1, 1'b1,1'b1,1'b1,1'b1,16'h0333,16'h1234,1'b1,3'd6,16'hBEEF,3'd1};
      tbl[21] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0,3'd0,3'd0,1'b1, 1'b1,1'b1,1'b1,1'b1,16'h0111,16'hBEEF,1'b0,3'd0,16'h0000,3'd0};
      tbl[22] = '{1'b1,1'b0,3'd0,16'h0000,1'b0,1'b0,3'd0,3'd0,1'b0, 1'b1,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,3'd0,16'h0000,3'd0};

      // Reset held for two edges with a writeback offered.
      drive(1'b0, 1'b1, 3'd3, 16'hAAAA, 1'b0, 1'b1, 3'd1, 3'd2, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rst, tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].dr,
               tbl[i].rv, tbl[i].s1, tbl[i].s2, tbl[i].ordy);
         #2;
         chk("wb_ready",     i, 16'(wb_ready),     16'(tbl[i].e_wbr));
         chk("rd_req_ready", i, 16'(rd_req_ready), 16'(tbl[i].e_rqr));
         chk("op_valid",     i, 16'(op_valid),     16'(tbl[i].e_ov));
         chk("rf_write_en",  i, 16'(rf_write_en),  16'(tbl[i].e_we));
         chk("rf_a3",        i, 16'(rf_a3),        16'(tbl[i].e_a3));
         chk("rf_wd3",       i, rf_wd3,            tbl[i].e_wd3);
         chk("wbq_count",    i, 16'(wbq_count),    16'(tbl[i].e_cnt));
         chk("rf_a1",        i, 16'(rf_a1),        16'(tbl[i].s1));
         if (tbl[i].e_chkop) begin
            chk("op1", i, op1, tbl[i].e_op1);
            chk("op2", i, op2, tbl[i].e_op2);
         end
         @(negedge clk);
      end

      // Same-cycle writeback outranks an older queued write to the same register.
      drive(1'b1, 1'b1, 3'd2, 16'h0AAA, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b1, 3'd3, 16'h0BBB, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b1, 3'd2, 16'h0CCC, 1'b0, 1'b1, 3'd2, 3'd3, 1'b1);
      #2;
      chk("seq_fwd_count", 100, 16'(wbq_count), 16'd2);
      @(negedge clk);

      // Reset asserted while draining a 3-deep queue.
      drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
      #2;
      chk("seq_fwd_op_valid", 101, 16'(op_valid), 16'd1);
      chk("seq_fwd_op1",      101, op1, 16'h0CCC);
      chk("seq_fwd_op2",      101, op2, 16'h0BBB);
      chk("seq_rst_count_pre",101, 16'(wbq_count), 16'd3);
      chk("seq_rst_we_in_rst",101, 16'(rf_write_en), 16'd0);
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
      #2;
      chk("seq_rst_count",    102, 16'(wbq_count), 16'd0);
      chk("seq_rst_we",       102, 16'(rf_write_en), 16'd0);
      chk("seq_rst_op_valid", 102, 16'(op_valid), 16'd0);
      chk("seq_rst_op1",      102, op1, 16'h0000);
      chk("seq_rst_wb_ready", 102, 16'(wb_ready), 16'd1);
      @(negedge clk);
      drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
      @(negedge clk);

      chk("total_rf_writes", 103, 16'(n_writes), 16'd7);
      chk("r0_writes",       103, 16'(n_r0_writes), 16'd0);
      chk("rf_r2_kept",      103, rfm[2], 16'h0022);
      chk("rf_r6_written",   103, rfm[6], 16'hBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
